// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair for mfhi/mflo.
// Optional multiply-accumulate (madd/maddu) is enabled by defining MDU_MADD_EN.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic               busy_q;

    logic [31:0]        hi_d;
    logic [31:0]        lo_d;
    logic [31:0]        a_mag_s;
    logic [31:0]        b_mag_s;
    logic [31:0]        b_div_s;
    logic [31:0]        sq_mag_s;
    logic [31:0]        sr_mag_s;
    logic [31:0]        sq_s;
    logic [31:0]        sr_s;
    logic [31:0]        uq_s;
    logic [31:0]        ur_s;
    logic [63:0]        smul_s;
    logic [63:0]        umul_s;

    // Result datapath: evaluated from latched operands, consumed on the final RUN edge.
    always_comb begin
        // Signed divide works on magnitudes so -2^31 / -1 wraps instead of overflowing.
        a_mag_s  = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag_s  = (b_q == 32'd0) ? 32'd1 : (b_q[31] ? (~b_q + 32'd1) : b_q);
        b_div_s  = (b_q == 32'd0) ? 32'd1 : b_q;
        sq_mag_s = a_mag_s / b_mag_s;
        sr_mag_s = a_mag_s % b_mag_s;
        sq_s     = (a_q[31] ^ b_q[31]) ? (~sq_mag_s + 32'd1) : sq_mag_s;
        sr_s     = a_q[31] ? (~sr_mag_s + 32'd1) : sr_mag_s;
        uq_s     = a_q / b_div_s;
        ur_s     = a_q % b_div_s;
        smul_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        umul_s   = {32'd0, a_q} * {32'd0, b_q};
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (op_q)
            OP_MULT:  {hi_d, lo_d} = smul_s;
            OP_MULTU: {hi_d, lo_d} = umul_s;
            OP_DIV: begin
                if (b_q != 32'd0) begin
                    hi_d = sr_s;
                    lo_d = sq_s;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    hi_d = ur_s;
                    lo_d = uq_s;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + smul_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + umul_s;
`endif
            default: begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        endcase
    end

    // Control FSM, operand latches, countdown and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
`ifdef MDU_MADD_EN
                            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
`else
                            OP_MULT, OP_MULTU: begin
`endif
                                op_q    <= op;
                                a_q     <= A;
                                b_q     <= B;
                                cnt_q   <= CNT_W'(MULT_CYCLES);
                                busy_q  <= 1'b1;
                                state_q <= ST_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q    <= op;
                                a_q     <= A;
                                b_q     <= B;
                                cnt_q   <= CNT_W'(DIV_CYCLES);
                                busy_q  <= 1'b1;
                                state_q <= ST_RUN;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed scenarios plus randomized ops
// compared every cycle against a transaction-level HI/LO model.
module tb_mdu_hilo;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit          m_busy;
    int          m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;

    always #5 clk = ~clk;

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: at a start edge, compute the final {HI,LO} and the cycle it lands on.
    task automatic model_edge();
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, prod, acc;
        int          lat;
        if (!reset) begin
            m_busy = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        end else if (m_busy) begin
            if (cyc == m_done) begin
                m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0;
            end
        end else if (start) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            ua = {32'd0, A};
            ub = {32'd0, B};
            lat = 0;
            p_hi = m_hi; p_lo = m_lo;
            case (op)
                4'd1: begin prod = 64'(sa * sb); {p_hi, p_lo} = prod; lat = MC; end
                4'd2: begin prod = ua * ub; {p_hi, p_lo} = prod; lat = MC; end
                4'd3: begin
                    lat = DC;
                    if (B != 32'd0) begin
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                end
                4'd4: begin
                    lat = DC;
                    if (B != 32'd0) begin
                        prod = ua / ub; acc = ua % ub;
                        p_lo = prod[31:0]; p_hi = acc[31:0];
                    end
                end
                4'd5: m_hi = A;
                4'd6: m_lo = A;
`ifdef MDU_MADD_EN
                4'd7: begin acc = {m_hi, m_lo} + 64'(sa * sb); {p_hi, p_lo} = acc; lat = MC; end
                4'd8: begin acc = {m_hi, m_lo} + ua * ub; {p_hi, p_lo} = acc; lat = MC; end
`endif
                default: lat = 0;
            endcase
            if (lat > 0) begin
                m_busy = 1'b1;
                m_done = cyc + lat;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_eq("busy", {63'd0, busy}, {63'd0, m_busy});
        check_eq("hi", {32'd0, HI}, {32'd0, m_hi});
        check_eq("lo", {32'd0, LO}, {32'd0, m_lo});
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        step();
        start = 1'b0; op = 4'd0;
    endtask

    task automatic wait_idle(input string tag, input int exp_cycles);
        int n = 1;
        while (busy && n < 100) begin
            step();
            if (busy) n++;
        end
        check_eq(tag, 64'(n), 64'(exp_cycles));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        m_busy = 1'b0; m_done = 0; m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0;
        #12;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_hi", {32'd0, HI}, 64'd0);
        check_eq("rst_lo", {32'd0, LO}, 64'd0);
        reset = 1'b1;

        issue(4'd1, 32'hFFFF_FFFF, 32'd3);
        wait_idle("mult_lat", MC);
        check_eq("mult_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check_eq("mult_lo", {32'd0, LO}, 64'hFFFF_FFFD);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle("multu_lat", MC);
        check_eq("multu_res", {HI, LO}, 64'h0000_0001_FFFF_FFFE);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_lat", DC);
        check_eq("div_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(4'd4, 32'd7, 32'd0);
        wait_idle("divz_lat", DC);
        check_eq("divz_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("divov_lat", DC);
        check_eq("divov_res", {HI, LO}, 64'h0000_0000_8000_0000);

        issue(4'd5, 32'h1234_5678, 32'd0);
        check_eq("mthi_busy", {63'd0, busy}, 64'd0);
        check_eq("mthi_hi", {32'd0, HI}, 64'h1234_5678);
        issue(4'd6, 32'h9ABC_DEF0, 32'd0);
        check_eq("mtlo_busy", {63'd0, busy}, 64'd0);
        check_eq("mtlo_res", {HI, LO}, 64'h1234_5678_9ABC_DEF0);

        // Undefined op and ignored mtlo while busy, then reset mid-operation.
        issue(4'd11, 32'hDEAD_BEEF, 32'd1);
        issue(4'd1, 32'd6, 32'd7);
        issue(4'd6, 32'h5555_5555, 32'd0);
        step();
        #2 reset = 1'b0;
        #1;
        m_busy = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        check_eq("arst_busy", {63'd0, busy}, 64'd0);
        check_eq("arst_hilo", {HI, LO}, 64'd0);
        repeat (2) step();
        #3 reset = 1'b1;
        repeat (MC + 2) step();
        check_eq("no_late_wr", {HI, LO}, 64'd0);

        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
        issue(4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_idle("madd_lat", MC);
        check_eq("madd_res", {HI, LO}, 64'h0000_0001_0000_0000);
`else
        check_eq("madd_busy", {63'd0, busy}, 64'd0);
        step();
        check_eq("madd_res", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            op    = 4'($urandom_range(0, 15));
            A     = pick_val();
            B     = pick_val();
            step();
        end
        start = 1'b0; op = 4'd0;
        repeat (DC + 2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core.
- Sits in the E stage and produces the HI/LO values that the pipeline carries forward to M and W for mfhi/mflo.
- Accepts one operation per start pulse and holds the result in internal HI/LO registers.
- Asserts busy while an operation is in flight so the hazard unit can stall any md-class instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset; clears all state
- start  input  1  one-cycle request; op/A/B sampled on the same edge
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu (7/8 only with macro)
- A  input  32  rs operand
- B  input  32  rt operand
- busy  output  1  operation in flight
- HI  output  32  current HI register
- LO  output  32  current LO register

Behaviour:
- Reset asserted (reset=0), at any time including mid-operation:
  - busy=0, HI=0, LO=0, counter=0, state IDLE.
  - Any pending result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- IDLE, start=1, op∈{1..4}, sampled at edge T:
  - Latch A, B and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from after edge T.
- RUN:
  - Counter decrements each edge.
  - At edge T+N (N = loaded count), HI/LO take the result, busy falls to 0, state returns to IDLE.
  - Result is visible to readers in cycle T+N.
- mult: {HI,LO} = signed(A)*signed(B), 64-bit.
- multu: unsigned 64-bit product.
- div: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
- divu: unsigned quotient/remainder.
- Divide by zero (B=0, div/divu): still occupies DIV_CYCLES; HI and LO are left unchanged at completion.
- div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- mthi/mtlo (op 5/6) with start=1 in IDLE:
  - HI (or LO) := A at that edge; busy stays 0; single cycle.
- start=1 while busy=1: ignored entirely, including mthi/mtlo. The hazard unit guarantees this does not occur; the block stays safe regardless.
- start=1 with op=0 or an undefined op: no effect.
- HI and LO outputs hold their old values throughout RUN; no intermediate values are exposed.
- Results are computed from the operands latched at the start edge; A/B changing during RUN has no effect.
- Implementation freedom: the result may be computed combinationally at start and delayed, or iteratively, provided the cycle-level behaviour above holds exactly.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 7 madd: {HI,LO} += signed(A)*signed(B).
  - op 8 maddu: unsigned accumulate.
  - Both use MULT_CYCLES latency.
  - Accumulation is 64-bit modulo 2^64, using the HI/LO values current at the start edge.
- Undefined: op 7/8 are treated as undefined ops (no effect, busy stays 0).

Test Plan:
- Reset, then mult with A=0xFFFFFFFF (-1), B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- multu with A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with A=7, B=0 -> HI/LO unchanged after 10 cycles.
- mthi A=0x12345678, next cycle mtlo A=0x9ABCDEF0 -> busy never rises; HI/LO updated on the respective edges.
- Start mult, pulse start with mtlo during busy, then drive reset low at cycle 3 -> mtlo ignored; on reset busy=0, HI=LO=0 immediately and no late result write.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0. Without the macro, the same op -> no change, busy=0.
